// File: rtl/mac_operand_feeder_pkg.sv
// Shared definitions for the MAC operand feeder: result width derivation,
// the fixed MAC latency contract and the frame-tracking state encoding.
package mac_operand_feeder_pkg;

    // Product issued in cycle t is visible on mac_result from cycle t+2.
    localparam int MAC_LATENCY = 2;

    typedef logic [1:0] frame_state_t;

    localparam frame_state_t ST_IDLE  = 2'd0;
    localparam frame_state_t ST_RUN   = 2'd1;
    localparam frame_state_t ST_DRAIN = 2'd2;

    function automatic int acc_width(input int width);
        return 2 * width + 1;
    endfunction

endpackage

// File: rtl/mac_feeder_fifo.sv
// Small synchronous operand FIFO with a fall-through head (rdata always shows
// the oldest entry). DEPTH must be a power of two and at least 2.
module mac_feeder_fifo
    import mac_operand_feeder_pkg::*;
#(
    parameter int W     = 17,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/mac_operand_feeder.sv
// Feeds operand pairs to the free-running MAC and reports per-frame dot products
// by differencing accumulator snapshots. Define MAC_FEEDER_STATS_EN for stat ports.
module mac_operand_feeder
    import mac_operand_feeder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8,
    localparam int ACC_W = acc_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_last,
    output logic [WIDTH-1:0] mac_a,
    output logic [WIDTH-1:0] mac_b,
    input  logic [ACC_W-1:0] mac_result,
    output logic             frame_valid,
    input  logic             frame_ready,
    output logic [ACC_W-1:0] frame_sum,
    output logic [CNT_W-1:0] frame_len
`ifdef MAC_FEEDER_STATS_EN
    ,
    output logic [15:0]      stat_frames,
    output logic [15:0]      stat_stall
`endif
);

    localparam int FW = 2 * WIDTH + 1;

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [FW-1:0]    fifo_wdata;
    logic [FW-1:0]    fifo_rdata;

    logic             head_last;
    logic [WIDTH-1:0] head_a;
    logic [WIDTH-1:0] head_b;
    logic             last_block;
    logic             head_stall;

    frame_state_t     state;
    logic [CNT_W-1:0] beat_cnt;
    logic [CNT_W-1:0] drain_len;

    logic             vld_p0;
    logic             first_p0;
    logic             last_p0;
    logic [WIDTH-1:0] a_p0;
    logic [WIDTH-1:0] b_p0;
    logic             first_p1;
    logic             last_p1;
    logic             last_p2;
    logic [ACC_W-1:0] base_acc;

    assign fifo_wdata                  = {in_last, in_a, in_b};
    assign {head_last, head_a, head_b} = fifo_rdata;

    assign in_ready  = rst_n & ~fifo_full;
    assign fifo_push = in_valid & in_ready;

    // A new last beat must wait until the single result slot and its snapshot are free.
    assign last_block = frame_valid | (state == ST_DRAIN);
    assign head_stall = ~fifo_empty & head_last & last_block;
    assign fifo_pop   = ~fifo_empty & ~head_stall;

    mac_feeder_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // ---- p0: issue cycle t, operands presented to the MAC ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0   <= 1'b0;
            first_p0 <= 1'b0;
            last_p0  <= 1'b0;
            a_p0     <= '0;
            b_p0     <= '0;
        end else begin
            vld_p0   <= fifo_pop;
            first_p0 <= fifo_pop & (beat_cnt == '0);
            last_p0  <= fifo_pop & head_last;
            a_p0     <= fifo_pop ? head_a : '0;
            b_p0     <= fifo_pop ? head_b : '0;
        end
    end

    assign mac_a = a_p0;
    assign mac_b = b_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (fifo_pop) begin
            beat_cnt <= head_last ? '0 : sat_inc_cnt(beat_cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_pop && head_last) begin
            drain_len <= sat_inc_cnt(beat_cnt);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fifo_pop) begin
                        state <= head_last ? ST_DRAIN : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (fifo_pop && head_last) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (last_p2) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // ---- p1: t+1, accumulator holds everything before the first beat ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_p1 <= 1'b0;
            last_p1  <= 1'b0;
        end else begin
            first_p1 <= vld_p0 & first_p0;
            last_p1  <= vld_p0 & last_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (first_p1) begin
            base_acc <= mac_result;
        end
    end

    // ---- p2: t+2, accumulator includes the last beat's product ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_p2 <= 1'b0;
        end else begin
            last_p2 <= last_p1;
        end
    end

    // ---- p3: result register; modular difference absorbs accumulator wrap ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_valid <= 1'b0;
            frame_sum   <= '0;
            frame_len   <= '0;
        end else if (last_p2) begin
            frame_valid <= 1'b1;
            frame_sum   <= mac_result - base_acc;
            frame_len   <= drain_len;
        end else if (frame_valid && frame_ready) begin
            frame_valid <= 1'b0;
        end
    end

`ifdef MAC_FEEDER_STATS_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_frames <= '0;
            stat_stall  <= '0;
        end else begin
            if (frame_valid && frame_ready) begin
                stat_frames <= stat_frames + 16'd1;
            end
            if (head_stall) begin
                stat_stall <= sat_inc16(stat_stall);
            end
        end
    end
`endif

endmodule

// File: doc/mac_operand_feeder.md
Name: mac_operand_feeder

Overview:
- Upstream stage of the pipelined multiply-accumulate unit.
- Accepts (A,B) operand pairs grouped into frames over a valid/ready stream, buffers them in a small FIFO, and drives the MAC operand inputs, with zeros on idle cycles so the free-running accumulator holds.
- Monitors the MAC accumulator output and reports each frame's dot product by differencing accumulator snapshots, so the MAC never needs clearing.

Parameters:
- WIDTH, 8, operand width; ACC_W = 2*WIDTH+1 is a derived localparam that matches the MAC result width.
- DEPTH, 4, operand FIFO entries; must be a power of 2 and at least 2.
- CNT_W, 8, width of the frame beat counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  FIFO can accept; equals not-full
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_last  in  1  final pair of the frame
- mac_a  out  WIDTH  registered operand to MAC A
- mac_b  out  WIDTH  registered operand to MAC B
- mac_result  in  ACC_W  MAC accumulator output
- frame_valid  out  1  frame result available
- frame_ready  in  1  consumer accepts frame result
- frame_sum  out  ACC_W  frame dot product, modulo 2^ACC_W
- frame_len  out  CNT_W  beats in frame, saturating at all-ones

Behaviour:
- Reset: FIFO empty, FSM IDLE, all flags cleared; in_ready=0 while rst_n=0 and 1 after; mac_a=mac_b=0, frame_valid=0, frame_sum=0, frame_len=0. Reset is honoured mid-frame: the partial frame is discarded and no frame_valid is produced for it.
- Input accept: a beat is accepted on in_valid&&in_ready. Simultaneous push and pop on a full FIFO is not allowed; in_ready is based on the current occupancy only.
- Issue: a beat pops from the FIFO when it is non-empty and not stalled. The popped beat drives mac_a/mac_b in the next cycle (the issue cycle t). Cycles with no issue drive mac_a=mac_b=0.
- Stall: a head beat with last=1 is not issued while frame_valid=1 or while a previously issued last beat is still in flight (DRAIN). Non-last beats are never stalled.
- MAC timing (fixed contract): the product issued in cycle t appears in mac_result from cycle t+2.
- Snapshots:
  - base = mac_result sampled in cycle t_first+1.
  - end = mac_result sampled in cycle t_last+2.
  - frame_sum = end - base, modulo 2^ACC_W, so accumulator wrap-around is harmless.
  - Back-to-back frames share that sample: the next frame's base equals the previous frame's end.
- Flag pipeline: first and last markers of issued beats are delayed 1 and 2 cycles to time the snapshots. A 1-beat frame has first=last on the same beat, with base at t+1 and end at t+2.
- FSM (frame tracking):
  - IDLE -> RUN on issue of a non-last beat.
  - IDLE -> DRAIN on issue of a last beat.
  - RUN -> DRAIN on issue of the last beat.
  - DRAIN -> IDLE at t_last+2, when frame_valid is set.
  - Issue of the next frame's first beat may overlap DRAIN.
- Output: frame_valid rises in cycle t_last+3 with frame_sum and frame_len. It holds stable until frame_valid&&frame_ready, then drops the next cycle.
- frame_len counts issued beats (not accepted beats) and saturates at 2^CNT_W-1.

Optional Feature:
- MAC_FEEDER_STATS_EN defined adds two outputs:
  - stat_frames (16 bits, wrapping): completed frames handed off.
  - stat_stall (16 bits, saturating): cycles where the FIFO head was stalled by the last-beat rule.
  - Both reset to 0.
- Undefined: the ports and counters are absent and the rest of the behaviour is identical.

Decomposition:
- Shared package holds:
  - ACC_W derivation function
  - MAC_LATENCY=2 constant
  - frame FSM state typedef (IDLE, RUN, DRAIN)
- Natural sub-module: mac_feeder_fifo, a DEPTH x (2*WIDTH+1) synchronous FIFO with push/pop/full/empty and async active-low reset. Snapshot, stall and FSM logic stay in the top.

Test Plan:
- Basic frame, with the testbench modelling the MAC: push (3,4),(5,6),(2,10 last) -> frame_valid with frame_sum=62, frame_len=3; mac_a/mac_b are 0 on idle cycles.
- Back-to-back frames: push (1,1 last),(2,3),(4,5 last) continuously -> frame sums 1 then 26, frame lens 1 then 2, no lost beat.
- Result backpressure: hold frame_ready=0 after frame 1 -> frame_sum stays stable and frame 2's last beat stalls. Push more beats until 4 beats sit in the FIFO -> in_ready=0. Release -> frame 2 result is correct.
- Accumulator wrap: run frames of (255,255) with the MAC pre-loaded near 2^17-1 -> frame_sum = 65025*n mod 2^17 is correct across the wrap.
- Reset mid-frame: assert rst_n=0 after 2 of 4 beats -> all outputs return to their reset values. The next full frame (7,8 last) gives frame_sum=56, frame_len=1.
- Stats (macro defined): 3 frames, with one forced 5-cycle stall -> stat_frames=3, stat_stall=5.
